axi4_rd_to_app: RTL and testbench

AXI4 read-channel front end for the DDR native ("app") interface. It accepts one AXI4 INCR read burst at a time and issues one app read command per beat. Returned `app_rd_data` beats are buffered in a credit-protected FIFO and replayed on the AXI R channel with RID/RLAST. It sits directly upstream of the MIG app port in `axi4_to_native`.

---
 rtl/axi4_to_native_pkg.sv | 15 +
 rtl/axi4_rd_to_app_if.sv | 55 +++++
 rtl/native_rd_fifo.sv | 63 ++++++
 rtl/axi4_rd_to_app.sv | 160 ++++++++++++++++
 tb/tb_axi4_rd_to_app.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_to_native_pkg.sv
// Shared constants and types for the AXI4 to DDR native-interface bridge.
package axi4_to_native_pkg;

    localparam logic [2:0] APP_CMD_READ   = 3'b001;
    localparam logic [2:0] APP_CMD_WRITE  = 3'b000;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/axi4_rd_to_app_if.sv
// AXI4 AR/R channels plus the DDR app read port, bundled for the read front end.
interface axi4_rd_to_app_if
    import axi4_to_native_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 27,
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH       = 4
);
    logic [ID_WIDTH-1:0]       s_axi_arid;
    logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr;
    logic [7:0]                s_axi_arlen;
    logic [2:0]                s_axi_arsize;
    logic [1:0]                s_axi_arburst;
    logic                      s_axi_arvalid;
    logic                      s_axi_arready;

    logic [ID_WIDTH-1:0]       s_axi_rid;
    logic [DATA_WIDTH-1:0]     s_axi_rdata;
    logic [1:0]                s_axi_rresp;
    logic                      s_axi_rlast;
    logic                      s_axi_rvalid;
    logic                      s_axi_rready;

    logic [ADDR_WIDTH-1:0]     app_addr;
    logic [2:0]                app_cmd;
    logic                      app_en;
    logic                      app_rdy;
    logic [DATA_WIDTH-1:0]     app_rd_data;
    logic                      app_rd_data_valid;
    logic                      app_rd_data_end;

    // Bridge side: AXI slave, app-port master.
    modport slave (
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
        input  s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready,
        output app_addr, app_cmd, app_en,
        input  app_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    // Environment side: AXI master and DDR controller.
    modport master (
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
        output s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready,
        input  app_addr, app_cmd, app_en,
        output app_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );

endinterface

// File: rtl/native_rd_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on rd_data whenever not empty.
module native_rd_fifo #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned DEPTH      = 32
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_n;
    logic                  full_q;
    logic                  empty_q;
    logic                  do_wr;
    logic                  do_rd;

    // Qualify requests against current occupancy and compute next fill level.
    always_comb begin
        do_wr   = wr_en && !full_q;
        do_rd   = rd_en && !empty_q;
        count_n = count_q + CW'(do_wr) - CW'(do_rd);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_n;
            full_q  <= (count_n == CW'(DEPTH));
            empty_q <= (count_n == '0);
        end
    end

    // Storage array; not reset, validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/axi4_rd_to_app.sv
// AXI4 read front end: one INCR burst at a time, one app read per beat,
// returned data buffered and replayed on R with a credit limit of FIFO_DEPTH.
module axi4_rd_to_app
    import axi4_to_native_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 27,
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned APP_ADDR_STEP  = 8,
    parameter int unsigned FIFO_DEPTH     = 32
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic            init_calib_complete,
    axi4_rd_to_app_if.slave bus
);
    localparam int unsigned BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int unsigned OW         = $clog2(FIFO_DEPTH) + 1;

    rd_state_e             state_q, state_n;
    logic [ID_WIDTH-1:0]   id_q, id_n;
    logic [7:0]            len_q, len_n;
    logic [7:0]            cmd_cnt_q, cmd_cnt_n;
    logic [7:0]            rbeat_q, rbeat_n;
    logic [OW-1:0]         outstanding_q, outstanding_n;
    logic [ADDR_WIDTH-1:0] app_addr_q, app_addr_n;
    logic                  app_en_q, app_en_n;
    logic [2:0]            app_cmd_q, app_cmd_n;
    logic                  arready_q, arready_n;
    logic                  rlast_q, rlast_n;

    logic [AXI_ADDR_WIDTH-1:0] word_idx;
    logic [ADDR_WIDTH-1:0]     base_addr;
    logic                      ar_hs;
    logic                      cmd_hs;
    logic                      r_hs;

    logic                  fifo_wr;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [OW-1:0]         fifo_count;
    logic                  unused_ok;

    // Sub-width arsize and non-INCR bursts are serviced as full-width INCR.
    assign unused_ok = ^{bus.s_axi_arsize, bus.s_axi_arburst, bus.app_rd_data_end,
                         fifo_full, fifo_count};

    assign word_idx  = bus.s_axi_araddr >> BYTE_SHIFT;
    assign base_addr = ADDR_WIDTH'(word_idx * AXI_ADDR_WIDTH'(APP_ADDR_STEP));

    assign ar_hs   = arready_q && bus.s_axi_arvalid;
    assign cmd_hs  = app_en_q && bus.app_rdy;
    assign r_hs    = !fifo_empty && bus.s_axi_rready;
    // Data arriving with nothing outstanding belongs to a burst killed by reset.
    assign fifo_wr = bus.app_rd_data_valid && (outstanding_q != '0);

    // Next-state and next-output logic.
    always_comb begin
        state_n       = state_q;
        id_n          = id_q;
        len_n         = len_q;
        cmd_cnt_n     = cmd_cnt_q;
        rbeat_n       = rbeat_q;
        app_addr_n    = app_addr_q;
        outstanding_n = outstanding_q;
        app_en_n      = 1'b0;
        app_cmd_n     = APP_CMD_WRITE;
        arready_n     = 1'b0;
        rlast_n       = 1'b0;

        if (r_hs) rbeat_n = rbeat_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    id_n       = bus.s_axi_arid;
                    len_n      = bus.s_axi_arlen;
                    app_addr_n = base_addr;
                    cmd_cnt_n  = 8'd0;
                    rbeat_n    = 8'd0;
                    state_n    = CMD;
                end
            end
            CMD: begin
                if (cmd_hs) begin
                    app_addr_n = app_addr_q + ADDR_WIDTH'(APP_ADDR_STEP);
                    cmd_cnt_n  = cmd_cnt_q + 8'd1;
                    if (cmd_cnt_q == len_q) state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (r_hs && rlast_q) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        outstanding_n = outstanding_q + OW'(cmd_hs) - OW'(r_hs);
        app_en_n      = (state_n == CMD) && (outstanding_n < OW'(FIFO_DEPTH));
        app_cmd_n     = (state_n == CMD) ? APP_CMD_READ : APP_CMD_WRITE;
        arready_n     = (state_n == IDLE) && init_calib_complete;
        rlast_n       = (state_n != IDLE) && (rbeat_n == len_n);
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            id_q          <= '0;
            len_q         <= '0;
            cmd_cnt_q     <= '0;
            rbeat_q       <= '0;
            outstanding_q <= '0;
            app_addr_q    <= '0;
            app_en_q      <= 1'b0;
            app_cmd_q     <= 3'b000;
            arready_q     <= 1'b0;
            rlast_q       <= 1'b0;
        end else begin
            state_q       <= state_n;
            id_q          <= id_n;
            len_q         <= len_n;
            cmd_cnt_q     <= cmd_cnt_n;
            rbeat_q       <= rbeat_n;
            outstanding_q <= outstanding_n;
            app_addr_q    <= app_addr_n;
            app_en_q      <= app_en_n;
            app_cmd_q     <= app_cmd_n;
            arready_q     <= arready_n;
            rlast_q       <= rlast_n;
        end
    end

    native_rd_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (bus.app_rd_data),
        .rd_en   (r_hs),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bus.s_axi_arready = arready_q;
    assign bus.s_axi_rid     = id_q;
    assign bus.s_axi_rdata   = fifo_rd_data;
    assign bus.s_axi_rresp   = AXI_RESP_OKAY;
    assign bus.s_axi_rlast   = rlast_q;
    assign bus.s_axi_rvalid  = !fifo_empty;
    assign bus.app_addr      = app_addr_q;
    assign bus.app_cmd       = app_cmd_q;
    assign bus.app_en        = app_en_q;

endmodule

// File: tb/tb_axi4_rd_to_app.sv
// Directed/random bench for axi4_rd_to_app with a DDR responder and burst-level reference.
module tb_axi4_rd_to_app;

    logic clock;
    logic rst_n;
    logic calib;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int unsigned rdy_prob = 100;
    int unsigned rready_prob = 100;

    logic [26:0]  cmd_addr_q[$];
    logic [2:0]   cmd_cmd_q[$];
    logic [26:0]  pend_addr[$];
    int unsigned  pend_due[$];
    int unsigned  last_due = 0;
    logic [255:0] r_data_q[$];
    logic [3:0]   r_id_q[$];
    logic         r_last_q[$];
    logic [1:0]   r_resp_q[$];
    int unsigned  last_r_edge = 0;
    int unsigned  ar_rise_cyc = 0;
    logic         prev_arready = 1'b0;
    logic         en_seen = 1'b0;

    logic [3:0]   e_id;
    logic [31:0]  e_addr;
    logic [7:0]   e_len;

    axi4_rd_to_app_if #(
        .ADDR_WIDTH(27), .DATA_WIDTH(256), .AXI_ADDR_WIDTH(32), .ID_WIDTH(4)
    ) bus ();

    axi4_rd_to_app #(
        .ADDR_WIDTH(27), .DATA_WIDTH(256), .AXI_ADDR_WIDTH(32), .ID_WIDTH(4),
        .APP_ADDR_STEP(8), .FIFO_DEPTH(32)
    ) dut (
        .clock               (clock),
        .rst_n               (rst_n),
        .init_calib_complete (calib),
        .bus                 (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    // DDR memory content as a function of the app address.
    function automatic logic [255:0] ddr_word(input logic [26:0] a);
        logic [255:0] d;
        for (int k = 0; k < 8; k++)
            d[k*32 +: 32] = (32'(a) * 32'h9E3779B1) ^ (32'(k) * 32'h01010101) ^ 32'h5A5A0000;
        return d;
    endfunction

    // Expected app address of beat i: word index of araddr times 8, plus 8 per beat, mod 2^27.
    function automatic logic [26:0] exp_addr(input logic [31:0] araddr, input int i);
        longint unsigned a;
        a = (longint'(araddr) / 32) * 8 + 8 * longint'(i);
        return 27'(a % (64'd1 << 27));
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // DDR controller model and bus monitor, all acting at the falling edge.
    initial begin
        int unsigned d;
        bus.app_rdy           = 1'b0;
        bus.s_axi_rready      = 1'b0;
        bus.app_rd_data_valid = 1'b0;
        bus.app_rd_data       = '0;
        bus.app_rd_data_end   = 1'b0;
        forever begin
            @(negedge clock);
            bus.app_rdy      = ($urandom_range(99) < rdy_prob);
            bus.s_axi_rready = ($urandom_range(99) < rready_prob);
            if (bus.app_en === 1'b1) en_seen = 1'b1;
            if (bus.app_en === 1'b1 && bus.app_rdy) begin
                cmd_addr_q.push_back(bus.app_addr);
                cmd_cmd_q.push_back(bus.app_cmd);
                pend_addr.push_back(bus.app_addr);
                d = cyc + $urandom_range(6, 2);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                pend_due.push_back(d);
            end
            if (bus.s_axi_rvalid === 1'b1 && bus.s_axi_rready) begin
                r_data_q.push_back(bus.s_axi_rdata);
                r_id_q.push_back(bus.s_axi_rid);
                r_last_q.push_back(bus.s_axi_rlast);
                r_resp_q.push_back(bus.s_axi_rresp);
                if (bus.s_axi_rlast === 1'b1) last_r_edge = cyc + 1;
            end
            if (bus.s_axi_arready === 1'b1 && !prev_arready) ar_rise_cyc = cyc;
            prev_arready = (bus.s_axi_arready === 1'b1);
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                bus.app_rd_data_valid = 1'b1;
                bus.app_rd_data       = ddr_word(pend_addr.pop_front());
                bus.app_rd_data_end   = 1'b1;
                void'(pend_due.pop_front());
                check("no_write_when_full", 256'(dut.u_fifo.full), 256'(0));
            end else begin
                bus.app_rd_data_valid = 1'b0;
                bus.app_rd_data_end   = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        cmd_addr_q.delete();
        cmd_cmd_q.delete();
        r_data_q.delete();
        r_id_q.delete();
        r_last_q.delete();
        r_resp_q.delete();
    endtask

    task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        e_id   = id;
        e_addr = addr;
        e_len  = len;
        clear_logs();
        bus.s_axi_arid    = id;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arlen   = len;
        bus.s_axi_arsize  = 3'($urandom_range(5));
        bus.s_axi_arburst = 2'($urandom_range(2));
        bus.s_axi_arvalid = 1'b1;
    endtask

    // Issue AR, wait for acceptance, then check app_en the cycle after the handshake.
    task automatic start_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        bit got;
        @(negedge clock);
        drive_ar(id, addr, len);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.s_axi_arready === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("ar_accept", 256'(got), 256'(1));
        @(negedge clock);
        bus.s_axi_arvalid = 1'b0;
        check("app_en_after_ar", 256'(bus.app_en), 256'(1));
    endtask

    // Wait for all beats, then compare command and R streams with the reference.
    task automatic finish_burst();
        int n;
        bit done;
        n = int'(e_len) + 1;
        done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (r_data_q.size() >= n) begin
                done = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("burst_done", 256'(done), 256'(1));
        repeat (2) @(negedge clock);
        check("cmd_count", 256'(cmd_addr_q.size()), 256'(n));
        check("beat_count", 256'(r_data_q.size()), 256'(n));
        for (int i = 0; i < n; i++) begin
            if (i < cmd_addr_q.size()) begin
                check($sformatf("app_addr[%0d]", i), 256'(cmd_addr_q[i]), 256'(exp_addr(e_addr, i)));
                check($sformatf("app_cmd[%0d]", i), 256'(cmd_cmd_q[i]), 256'(3'b001));
            end
            if (i < r_data_q.size()) begin
                check($sformatf("rdata[%0d]", i), r_data_q[i], ddr_word(exp_addr(e_addr, i)));
                check($sformatf("rid[%0d]", i), 256'(r_id_q[i]), 256'(e_id));
                check($sformatf("rlast[%0d]", i), 256'(r_last_q[i]), 256'(i == n - 1));
                check($sformatf("rresp[%0d]", i), 256'(r_resp_q[i]), 256'(0));
            end
        end
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        start_burst(id, addr, len);
        finish_burst();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_arready"}, 256'(bus.s_axi_arready), 256'(0));
        check({pfx, "_app_en"},  256'(bus.app_en),        256'(0));
        check({pfx, "_app_cmd"}, 256'(bus.app_cmd),       256'(0));
        check({pfx, "_app_addr"}, 256'(bus.app_addr),     256'(0));
        check({pfx, "_rvalid"},  256'(bus.s_axi_rvalid),  256'(0));
        check({pfx, "_rlast"},   256'(bus.s_axi_rlast),   256'(0));
        check({pfx, "_rid"},     256'(bus.s_axi_rid),     256'(0));
        check({pfx, "_rresp"},   256'(bus.s_axi_rresp),   256'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit stale_seen;
        rst_n = 1'b0;
        calib = 1'b0;
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_arid    = '0;
        bus.s_axi_araddr  = '0;
        bus.s_axi_arlen   = '0;
        bus.s_axi_arsize  = '0;
        bus.s_axi_arburst = '0;

        // Reset values
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Calibration gate followed by a single-beat burst at 0x40
        @(negedge clock);
        en_seen = 1'b0;
        drive_ar(4'd3, 32'h0000_0040, 8'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check($sformatf("calib_gate_arready[%0d]", i), 256'(bus.s_axi_arready), 256'(0));
        end
        check("calib_gate_no_app_en", 256'(en_seen), 256'(0));
        calib = 1'b1;
        @(negedge clock);
        check("calib_arready", 256'(bus.s_axi_arready), 256'(1));
        @(negedge clock);
        bus.s_axi_arvalid = 1'b0;
        check("single_app_en", 256'(bus.app_en), 256'(1));
        check("single_app_addr", 256'(bus.app_addr), 256'(27'h10));
        finish_burst();

        // Random app_rdy and rready handshakes
        rdy_prob    = 50;
        rready_prob = 50;
        run_burst(4'd7, 32'h0000_0000, 8'd15);

        // Credit stall: no R drain, commands must stop at FIFO depth
        rdy_prob    = 100;
        rready_prob = 0;
        start_burst(4'd4, 32'h0000_1000, 8'd63);
        repeat (60) @(negedge clock);
        check("stall_cmd_count", 256'(cmd_addr_q.size()), 256'(32));
        check("stall_app_en", 256'(bus.app_en), 256'(0));
        rready_prob = 100;
        finish_burst();

        // Back-to-back bursts and turnaround
        run_burst(4'd1, 32'h0000_0200, 8'd3);
        check("turnaround_arready", 256'(ar_rise_cyc), 256'(last_r_edge));
        run_burst(4'd2, 32'h0000_0400, 8'd0);

        // App address wraps modulo 2^27
        run_burst(4'd9, 32'hFFFF_FFE0, 8'd3);

        // Reset in the middle of a command phase
        rdy_prob    = 100;
        rready_prob = 0;
        start_burst(4'd6, 32'h0000_0800, 8'd7);
        repeat (2) @(negedge clock);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        stale_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (bus.s_axi_rvalid === 1'b1) stale_seen = 1'b1;
            if (pend_addr.size() == 0) break;
        end
        repeat (3) @(negedge clock);
        if (bus.s_axi_rvalid === 1'b1) stale_seen = 1'b1;
        check("stale_pending_drained", 256'(pend_addr.size()), 256'(0));
        check("stale_data_dropped", 256'(stale_seen), 256'(0));
        rready_prob = 100;
        run_burst(4'd5, 32'h0000_02A0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
